// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The datapath side (master) supplies instruction fields and ALU flags.
// The controller side (slave) returns the control word and the current state.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       slt_check;
  logic [2:0] alu_sel;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       mem_write;
  logic       reg_write;
  logic [3:0] state;

  modport master (
    output opcode, funct3, funct7b5, zero, slt_check,
    input  alu_sel, alu_src_a, alu_src_b, result_src, imm_src,
           adr_src, ir_write, pc_write, mem_write, reg_write, state
  );

  modport slave (
    input  opcode, funct3, funct7b5, zero, slt_check,
    output alu_sel, alu_src_a, alu_src_b, result_src, imm_src,
           adr_src, ir_write, pc_write, mem_write, reg_write, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller: an FSM that sequences fetch,
// decode, execute, memory and writeback, plus combinational ALU and
// immediate-format decoders.
module multicycle_controller (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.slave bus
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    ALU_WB    = 4'd7,
    EXEC_I    = 4'd8,
    JAL       = 4'd9,
    BRANCH    = 4'd10
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] alu_sel, imm_src, alu_dec;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, pc_write, mem_write, reg_write;
  logic       use_sub;
  logic       branch_taken;

  // State register; reset lands on FETCH immediately, without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  // ALU operation from funct3; subtract only for R-type with funct7b5 set.
  always_comb begin
    use_sub = (state_reg == EXEC_R) && bus.funct7b5;
    case (bus.funct3)
      3'b000:  alu_dec = use_sub ? 3'b001 : 3'b000;
      3'b111:  alu_dec = 3'b010;
      3'b110:  alu_dec = 3'b011;
      3'b010:  alu_dec = 3'b100;
      3'b100:  alu_dec = 3'b101;
      default: alu_dec = 3'b000;
    endcase
  end

  // Branch condition from funct3 and the ALU flags.
  always_comb begin
    case (bus.funct3)
      3'b000:  branch_taken = bus.zero;
      3'b001:  branch_taken = ~bus.zero;
      3'b100:  branch_taken = bus.slt_check;
      3'b101:  branch_taken = ~bus.slt_check;
      default: branch_taken = 1'b0;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (bus.opcode)
      OP_SW:   imm_src = 3'b001;
      OP_BR:   imm_src = 3'b010;
      OP_JAL:  imm_src = 3'b011;
      default: imm_src = 3'b000;
    endcase
  end

  // Next state and per-state control word; everything is zero unless a state sets it.
  always_comb begin
    state_next = FETCH;
    alu_sel    = 3'b000;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    case (state_reg)
      FETCH: begin
        state_next = DECODE;
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = MEM_ADR;
          OP_R:         state_next = EXEC_R;
          OP_I:         state_next = EXEC_I;
          OP_JAL:       state_next = JAL;
          OP_BR:        state_next = BRANCH;
          default:      state_next = FETCH;
        endcase
      end
      MEM_ADR: begin
        state_next = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
      end
      MEM_READ: begin
        state_next = MEM_WB;
        adr_src    = 1'b1;
      end
      MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXEC_R: begin
        state_next = ALU_WB;
        alu_src_a  = 2'b10;
        alu_sel    = alu_dec;
      end
      EXEC_I: begin
        state_next = ALU_WB;
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_sel    = alu_dec;
      end
      ALU_WB: begin
        reg_write = 1'b1;
      end
      JAL: begin
        state_next = ALU_WB;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_sel   = 3'b001;
        pc_write  = branch_taken;
      end
      default: state_next = FETCH;
    endcase
    // Held in reset the block sits in FETCH but must not strobe anything.
    if (!rst_n) begin
      alu_sel    = 3'b000;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
    end
  end

  assign bus.alu_sel    = alu_sel;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.result_src = result_src;
  assign bus.imm_src    = imm_src;
  assign bus.adr_src    = adr_src;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.state      = state_reg;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver issues whole
// instructions and queues the expected control word of every cycle; a
// negedge monitor pops and compares.
module tb_multicycle_controller;
  logic clk;
  logic rst_n;
  multicycle_controller_if bus ();

  multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] sel;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [2:0] imm;
    logic       adr;
    logic       ir;
    logic       pc;
    logic       mw;
    logic       rw;
  } exp_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BR = 5, C_NOP = 6;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] op_of(int cls);
    case (cls)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_JAL:   return 7'b1101111;
      C_BR:    return 7'b1100011;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    for (int k = 0; k < 6; k++) if (op == op_of(k)) return 1'b1;
    return 1'b0;
  endfunction

  // Cycles per instruction, FETCH included.
  function automatic int len_of(int cls);
    case (cls)
      C_LW:    return 5;
      C_BR:    return 3;
      C_NOP:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] op);
    if (op == op_of(C_SW))  return 3'd1;
    if (op == op_of(C_BR))  return 3'd2;
    if (op == op_of(C_JAL)) return 3'd3;
    return 3'd0;
  endfunction

  // Mnemonic meaning of funct3: add/sub, and, or, slt, xor.
  function automatic logic [2:0] alu_of(logic [2:0] f3, logic f7, bit is_r);
    if (f3 == 3'd0) return (is_r && f7) ? 3'd1 : 3'd0;
    if (f3 == 3'd7) return 3'd2;
    if (f3 == 3'd6) return 3'd3;
    if (f3 == 3'd2) return 3'd4;
    if (f3 == 3'd4) return 3'd5;
    return 3'd0;
  endfunction

  function automatic logic taken_of(logic [2:0] f3, logic z, logic s);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4) return s;
    if (f3 == 3'd5) return !s;
    return 1'b0;
  endfunction

  // Expected control word for step n of an instruction of class cls.
  function automatic exp_t model(int cls, int n, logic [6:0] op, logic [2:0] f3,
                                 logic f7, logic z, logic s);
    exp_t e;
    e = '0;
    e.imm = imm_of(op);
    if (n == 0) begin
      e.st = 4'd0; e.ir = 1; e.pc = 1; e.b = 2'd2; e.rs = 2'd2;
    end else if (n == 1) begin
      e.st = 4'd1; e.a = 2'd1; e.b = 2'd1;
    end else begin
      case (cls)
        C_LW: begin
          if (n == 2)      begin e.st = 4'd2; e.a = 2'd2; e.b = 2'd1; end
          else if (n == 3) begin e.st = 4'd3; e.adr = 1; end
          else             begin e.st = 4'd4; e.rs = 2'd1; e.rw = 1; end
        end
        C_SW: begin
          if (n == 2) begin e.st = 4'd2; e.a = 2'd2; e.b = 2'd1; end
          else        begin e.st = 4'd5; e.adr = 1; e.mw = 1; end
        end
        C_R: begin
          if (n == 2) begin e.st = 4'd6; e.a = 2'd2; e.sel = alu_of(f3, f7, 1); end
          else        begin e.st = 4'd7; e.rw = 1; end
        end
        C_I: begin
          if (n == 2) begin e.st = 4'd8; e.a = 2'd2; e.b = 2'd1; e.sel = alu_of(f3, f7, 0); end
          else        begin e.st = 4'd7; e.rw = 1; end
        end
        C_JAL: begin
          if (n == 2) begin e.st = 4'd9; e.a = 2'd1; e.b = 2'd2; e.pc = 1; end
          else        begin e.st = 4'd7; e.rw = 1; end
        end
        default: begin
          e.st = 4'd10; e.a = 2'd2; e.sel = 3'd1; e.pc = taken_of(f3, z, s);
        end
      endcase
    end
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t g;
    g.st = bus.state;   g.sel = bus.alu_sel;  g.a = bus.alu_src_a;
    g.b = bus.alu_src_b; g.rs = bus.result_src; g.imm = bus.imm_src;
    g.adr = bus.adr_src; g.ir = bus.ir_write;  g.pc = bus.pc_write;
    g.mw = bus.mem_write; g.rw = bus.reg_write;
    return g;
  endfunction

  // Monitor: one comparison per active cycle.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      exp_t e, g;
      e = sb.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle_word t=%0t got=%h required=%h (state got %0d required %0d)",
                 $time, g, e, g.st, e.st);
      end
    end
  end

  task automatic check_val(string name, logic [31:0] got, logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Issue one instruction; entered and left just after a rising edge.
  // zf/sf < 0 pick random flags each cycle; steps limits the cycles issued.
  task automatic run_instr(int cls, logic [6:0] op, logic [2:0] f3, logic f7,
                           int zf, int sf, int steps);
    int n_max;
    n_max = (steps < len_of(cls)) ? steps : len_of(cls);
    $display("instr cls=%0d op=%b f3=%0d f7=%0d cycles=%0d", cls, op, f3, f7, n_max);
    for (int n = 0; n < n_max; n++) begin
      bus.opcode    = op;
      bus.funct3    = f3;
      bus.funct7b5  = f7;
      bus.zero      = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      bus.slt_check = (sf < 0) ? 1'($urandom_range(0, 1)) : 1'(sf);
      sb.push_back(model(cls, n, op, f3, f7, bus.zero, bus.slt_check));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_quiet(string name);
    check_val({name, "_state"}, 32'(bus.state), 32'd0);
    check_val({name, "_strobes"},
              32'({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write}), 32'd0);
    check_val({name, "_selects"},
              32'({bus.alu_sel, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.adr_src}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cls;
    logic [6:0] op;
    rst_n = 1'b0;
    bus.opcode = op_of(C_SW); bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.slt_check = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_quiet("reset");
    check_val("reset_imm_src", 32'(bus.imm_src), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed: lw, sub, blt both ways, bne both ways, unknown opcode, I-type add.
    run_instr(C_LW, op_of(C_LW), 3'd2, 1'b0, -1, -1, 99);
    run_instr(C_R, op_of(C_R), 3'd0, 1'b1, -1, -1, 99);
    run_instr(C_BR, op_of(C_BR), 3'd4, 1'b0, 0, 1, 99);
    run_instr(C_BR, op_of(C_BR), 3'd4, 1'b0, 1, 0, 99);
    run_instr(C_BR, op_of(C_BR), 3'd1, 1'b0, 1, 0, 99);
    run_instr(C_BR, op_of(C_BR), 3'd1, 1'b0, 0, 1, 99);
    run_instr(C_NOP, 7'b1111111, 3'd0, 1'b0, -1, -1, 99);
    run_instr(C_I, op_of(C_I), 3'd0, 1'b1, -1, -1, 99);
    run_instr(C_JAL, op_of(C_JAL), 3'd5, 1'b1, -1, -1, 99);

    // Reset while in MEM_WRITE, no clock edge needed to take effect.
    run_instr(C_SW, op_of(C_SW), 3'd2, 1'b0, -1, -1, 3);
    check_val("pre_reset_state", 32'(bus.state), 32'd5);
    check_val("pre_reset_mem_write", 32'(bus.mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_quiet("async_reset");
    @(posedge clk);
    #1;
    check_val("held_reset_state", 32'(bus.state), 32'd0);
    rst_n = 1'b1;
    run_instr(C_R, op_of(C_R), 3'd7, 1'b0, -1, -1, 99);

    // Reset in the middle of lw (MEM_READ).
    run_instr(C_LW, op_of(C_LW), 3'd2, 1'b0, -1, -1, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_quiet("mid_lw_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random instruction mix.
    for (int i = 0; i < 200; i++) begin
      cls = int'($urandom_range(0, 6));
      op = op_of(cls);
      if (cls == C_NOP) begin
        do op = 7'($urandom_range(0, 127)); while (is_legal(op));
      end
      run_instr(cls, op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1, 99);
    end

    repeat (3) @(negedge clk);
    check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
